phv_queue_merger: RTL and testbench

- Reverse end of the last-stage fan-out: reads the four per-queue PHV FIFOs that the last pipeline stage fills, and merges them into one PHV stream for the deparser.
- Uses work-conserving round-robin arbitration, a single registered output slot with valid/ready handshake, per-queue dequeue counters, and a check of the one-hot queue bits.

---
 rtl/rmt_pkg.sv | 13 +
 rtl/rr_arbiter_4.sv | 28 ++
 rtl/phv_queue_merger.sv | 105 ++++++++++
 tb/tb_phv_queue_merger.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_pkg.sv
// Constants shared by the last-stage fan-out and the queue merger.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package rmt_pkg;
    localparam int PHV_LEN      = 1024;
    localparam int C_NUM_QUEUES = 4;
    localparam int QID_OFF      = 141;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;
endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter; the search starts at ptr and wraps.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter_4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt_onehot,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);
    logic [1:0] idx;

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        idx        = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                gnt_onehot = 4'b0001 << idx;
                gnt_idx    = idx;
                gnt_valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/phv_queue_merger.sv
// Merges the four per-queue PHV FIFOs into one stream with round-robin arbitration.
// Latency: 1 cycle from a valid head entry (slot free) to phv_out_valid.
// Backpressure: ready_in low holds the output slot stable and stops all pops.
module phv_queue_merger
    import rmt_pkg::*;
#(
    parameter int PHV_LEN_P    = PHV_LEN,
    parameter int C_NUM_QUEUES_P = C_NUM_QUEUES,
    parameter int QID_OFF_P    = QID_OFF,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 axis_clk,
    input  logic                 areset,
    input  logic [PHV_LEN_P-1:0] phv_in_0,
    input  logic [PHV_LEN_P-1:0] phv_in_1,
    input  logic [PHV_LEN_P-1:0] phv_in_2,
    input  logic [PHV_LEN_P-1:0] phv_in_3,
    input  logic                 phv_in_valid_0,
    input  logic                 phv_in_valid_1,
    input  logic                 phv_in_valid_2,
    input  logic                 phv_in_valid_3,
    output logic                 phv_in_rd_0,
    output logic                 phv_in_rd_1,
    output logic                 phv_in_rd_2,
    output logic                 phv_in_rd_3,
    output logic [PHV_LEN_P-1:0] phv_out,
    output logic                 phv_out_valid,
    output logic [1:0]           phv_out_qid,
    input  logic                 ready_in,
    output logic [CNT_WIDTH-1:0] deq_cnt_0,
    output logic [CNT_WIDTH-1:0] deq_cnt_1,
    output logic [CNT_WIDTH-1:0] deq_cnt_2,
    output logic [CNT_WIDTH-1:0] deq_cnt_3,
    output logic [CNT_WIDTH-1:0] qid_mismatch_cnt
);
    state_t                      state;
    logic [1:0]                  rr_ptr;
    logic [PHV_LEN_P-1:0]        phv_in [4];
    logic [CNT_WIDTH-1:0]        deq_cnt [4];
    logic [3:0]                  gnt_onehot;
    logic [1:0]                  gnt_idx;
    logic                        gnt_valid;
    logic                        free;
    logic                        capture;
    logic [PHV_LEN_P-1:0]        phv_sel;
    logic [C_NUM_QUEUES_P-1:0]   qid_field;
    logic                        qid_hit;

    assign phv_in[0] = phv_in_0;
    assign phv_in[1] = phv_in_1;
    assign phv_in[2] = phv_in_2;
    assign phv_in[3] = phv_in_3;

    rr_arbiter_4 u_arb (
        .req        ({phv_in_valid_3, phv_in_valid_2, phv_in_valid_1, phv_in_valid_0}),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    // Reset is gated in so a pop is never issued for an entry that will not be kept.
    assign free    = (state == ST_EMPTY) || ready_in;
    assign capture = free && gnt_valid && !areset;

    assign phv_in_rd_0 = capture & gnt_onehot[0];
    assign phv_in_rd_1 = capture & gnt_onehot[1];
    assign phv_in_rd_2 = capture & gnt_onehot[2];
    assign phv_in_rd_3 = capture & gnt_onehot[3];

    assign phv_sel   = phv_in[gnt_idx];
    assign qid_field = phv_sel[QID_OFF_P +: C_NUM_QUEUES_P];
    assign qid_hit   = qid_field[gnt_idx];

    always_ff @(posedge axis_clk) begin
        if (areset) begin
            state            <= ST_EMPTY;
            rr_ptr           <= '0;
            phv_out          <= '0;
            phv_out_valid    <= 1'b0;
            phv_out_qid      <= '0;
            qid_mismatch_cnt <= '0;
            for (int k = 0; k < 4; k++) deq_cnt[k] <= '0;
        end else if (capture) begin
            state         <= ST_FULL;
            phv_out       <= phv_sel;
            phv_out_qid   <= gnt_idx;
            phv_out_valid <= 1'b1;
            rr_ptr        <= gnt_idx + 2'd1;
            if (deq_cnt[gnt_idx] != '1)
                deq_cnt[gnt_idx] <= deq_cnt[gnt_idx] + CNT_WIDTH'(1);
            // Multicast PHVs carry extra bits; only a missing own bit counts.
            if (!qid_hit && (qid_mismatch_cnt != '1))
                qid_mismatch_cnt <= qid_mismatch_cnt + CNT_WIDTH'(1);
        end else if (free) begin
            state         <= ST_EMPTY;
            phv_out_valid <= 1'b0;
        end
    end

    assign deq_cnt_0 = deq_cnt[0];
    assign deq_cnt_1 = deq_cnt[1];
    assign deq_cnt_2 = deq_cnt[2];
    assign deq_cnt_3 = deq_cnt[3];
endmodule

// File: tb/tb_phv_queue_merger.sv
// Directed bench for phv_queue_merger: FIFO models feed four queues, a second
// narrow-counter instance exercises counter saturation.
module tb_phv_queue_merger;
    localparam int PL = 1024;

    logic          axis_clk = 1'b0;
    logic          areset;
    logic          ready_in;
    logic [PL-1:0] phv_in [4];
    logic [3:0]    vld;
    logic          rd0, rd1, rd2, rd3;
    logic [3:0]    rd;
    logic [PL-1:0] phv_out;
    logic          phv_out_valid;
    logic [1:0]    phv_out_qid;
    logic [31:0]   dc0, dc1, dc2, dc3, mm;

    logic [PL-1:0] s_phv;
    logic [PL-1:0] s_zero;
    logic          s_vld0;
    logic          s_rd0, s_rd1, s_rd2, s_rd3;
    logic [PL-1:0] s_out;
    logic          s_out_valid;
    logic [1:0]    s_qid;
    logic [3:0]    s_dc0, s_dc1, s_dc2, s_dc3, s_mm;

    logic [PL-1:0] mem [4][8];
    int            head [4];
    int            tail [4];
    int            n_total = 0;
    int            n_fail  = 0;

    always #5 axis_clk = ~axis_clk;
    assign rd = {rd3, rd2, rd1, rd0};

    phv_queue_merger dut (
        .axis_clk(axis_clk), .areset(areset),
        .phv_in_0(phv_in[0]), .phv_in_1(phv_in[1]), .phv_in_2(phv_in[2]), .phv_in_3(phv_in[3]),
        .phv_in_valid_0(vld[0]), .phv_in_valid_1(vld[1]), .phv_in_valid_2(vld[2]), .phv_in_valid_3(vld[3]),
        .phv_in_rd_0(rd0), .phv_in_rd_1(rd1), .phv_in_rd_2(rd2), .phv_in_rd_3(rd3),
        .phv_out(phv_out), .phv_out_valid(phv_out_valid), .phv_out_qid(phv_out_qid),
        .ready_in(ready_in),
        .deq_cnt_0(dc0), .deq_cnt_1(dc1), .deq_cnt_2(dc2), .deq_cnt_3(dc3),
        .qid_mismatch_cnt(mm)
    );

    phv_queue_merger #(.CNT_WIDTH(4)) dut_s (
        .axis_clk(axis_clk), .areset(areset),
        .phv_in_0(s_phv), .phv_in_1(s_zero), .phv_in_2(s_zero), .phv_in_3(s_zero),
        .phv_in_valid_0(s_vld0), .phv_in_valid_1(1'b0), .phv_in_valid_2(1'b0), .phv_in_valid_3(1'b0),
        .phv_in_rd_0(s_rd0), .phv_in_rd_1(s_rd1), .phv_in_rd_2(s_rd2), .phv_in_rd_3(s_rd3),
        .phv_out(s_out), .phv_out_valid(s_out_valid), .phv_out_qid(s_qid),
        .ready_in(1'b1),
        .deq_cnt_0(s_dc0), .deq_cnt_1(s_dc1), .deq_cnt_2(s_dc2), .deq_cnt_3(s_dc3),
        .qid_mismatch_cnt(s_mm)
    );

    function automatic logic [PL-1:0] make_phv(input logic [31:0] tag, input logic [3:0] qbits);
        logic [PL-1:0] p;
        p = '0;
        p[31:0]    = tag;
        p[144:141] = qbits;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            vld[k]    = (head[k] != tail[k]);
            phv_in[k] = vld[k] ? mem[k][head[k]] : '0;
        end
    endtask

    task automatic push(input int k, input logic [31:0] tag, input logic [3:0] qbits);
        mem[k][tail[k]] = make_phv(tag, qbits);
        tail[k] = (tail[k] + 1) % 8;
    endtask

    // Pops are taken from the rd values seen before the edge, then inputs settle.
    task automatic tick();
        logic [3:0] r;
        r = rd;
        @(posedge axis_clk);
        #1;
        for (int k = 0; k < 4; k++)
            if (r[k]) head[k] = (head[k] + 1) % 8;
        drive();
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        #1;
    endtask

    initial begin
        areset   = 1'b1;
        ready_in = 1'b1;
        s_zero   = '0;
        s_phv    = make_phv(32'h5a5a, 4'b0000);
        s_vld0   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
        drive();
        do_reset();

        chk("rst_valid", 64'(phv_out_valid), 64'd0);
        chk("rst_data",  phv_out[63:0], 64'd0);
        chk("rst_qid",   64'(phv_out_qid), 64'd0);
        chk("rst_rd",    64'(rd), 64'd0);
        chk("rst_cnt",   64'(dc0 | dc1 | dc2 | dc3 | mm), 64'd0);

        // Single PHV on queue 2 with its own bit (143) set.
        push(2, 32'h200, 4'b0100);
        drive(); #1;
        chk("single_rd", 64'(rd), 64'h4);
        tick();
        chk("single_valid", 64'(phv_out_valid), 64'd1);
        chk("single_qid",   64'(phv_out_qid), 64'd2);
        chk("single_tag",   phv_out[63:0], 64'h200);
        chk("single_rd_off", 64'(rd), 64'd0);
        chk("single_deq2",  64'(dc2), 64'd1);
        chk("single_mm",    64'(mm), 64'd0);
        tick();
        chk("single_drain", 64'(phv_out_valid), 64'd0);

        // All four queues hold three PHVs each: strict 0,1,2,3 order, no bubbles.
        do_reset();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++)
                push(k, 32'h1000 + 32'(k * 16 + i), 4'(1 << k));
        drive(); #1;
        for (int n = 0; n < 12; n++) begin
            tick();
            chk("full_valid", 64'(phv_out_valid), 64'd1);
            chk("full_qid",   64'(phv_out_qid), 64'(n % 4));
            chk("full_tag",   phv_out[63:0], 64'(32'h1000 + 32'((n % 4) * 16 + n / 4)));
        end
        chk("full_deq0", 64'(dc0), 64'd3);
        chk("full_deq1", 64'(dc1), 64'd3);
        chk("full_deq2", 64'(dc2), 64'd3);
        chk("full_deq3", 64'(dc3), 64'd3);
        chk("full_mm",   64'(mm), 64'd0);
        tick();
        chk("full_drain", 64'(phv_out_valid), 64'd0);

        // Backpressure with queues 1 and 3 valid; rr_ptr is 0 here.
        ready_in = 1'b0;
        push(1, 32'hA1, 4'b0010);
        push(3, 32'hB3, 4'b1000);
        drive(); #1;
        chk("bp_first_rd", 64'(rd), 64'h2);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 64'(phv_out_valid), 64'd1);
            chk("bp_qid",   64'(phv_out_qid), 64'd1);
            chk("bp_tag",   phv_out[63:0], 64'hA1);
            chk("bp_rd",    64'(rd), 64'd0);
            tick();
        end
        ready_in = 1'b1;
        #1;
        chk("bp_release_rd", 64'(rd), 64'h8);
        tick();
        chk("bp_next_qid", 64'(phv_out_qid), 64'd3);
        chk("bp_next_tag", phv_out[63:0], 64'hB3);
        tick();
        chk("bp_drain", 64'(phv_out_valid), 64'd0);

        // Queue 0 PHV carrying only bit 2 is a mismatch; a multicast PHV is not.
        push(0, 32'hC0, 4'b0100);
        drive(); #1;
        tick();
        chk("mm_qid", 64'(phv_out_qid), 64'd0);
        chk("mm_tag", phv_out[63:0], 64'hC0);
        chk("mm_bits", 64'(phv_out[144:141]), 64'h4);
        chk("mm_cnt", 64'(mm), 64'd1);
        push(1, 32'hC1, 4'b0110);
        drive(); #1;
        tick();
        chk("mc_qid", 64'(phv_out_qid), 64'd1);
        chk("mc_cnt", 64'(mm), 64'd1);
        tick();

        // Reset while stalled: rr_ptr is 2 before reset, so the post-reset grant
        // distinguishes rr_ptr=0 (queue 1) from a stale pointer (queue 3).
        ready_in = 1'b0;
        push(1, 32'hD1, 4'b0010);
        drive(); #1;
        tick();
        chk("rs_held_qid", 64'(phv_out_qid), 64'd1);
        push(1, 32'hE1, 4'b0010);
        push(3, 32'hE3, 4'b1000);
        drive(); #1;
        areset = 1'b1;
        #1;
        chk("rs_rd_gated", 64'(rd), 64'd0);
        tick();
        areset = 1'b0;
        #1;
        chk("rs_valid", 64'(phv_out_valid), 64'd0);
        chk("rs_cnt",   64'(dc0 | dc1 | dc2 | dc3 | mm), 64'd0);
        chk("rs_grant", 64'(rd), 64'h2);
        ready_in = 1'b1;
        tick();
        chk("rs_out_qid", 64'(phv_out_qid), 64'd1);
        chk("rs_out_tag", phv_out[63:0], 64'hE1);
        chk("rs_deq1",    64'(dc1), 64'd1);
        tick();
        chk("rs_next_qid", 64'(phv_out_qid), 64'd3);
        tick();
        chk("rs_drain", 64'(phv_out_valid), 64'd0);

        // Saturation on the 4-bit counter instance: 20 dequeues of mismatching PHVs.
        s_vld0 = 1'b1;
        #1;
        for (int n = 0; n < 15; n++) tick();
        chk("sat_deq_at15", 64'(s_dc0), 64'hF);
        chk("sat_mm_at15",  64'(s_mm), 64'hF);
        for (int n = 0; n < 5; n++) tick();
        chk("sat_deq_hold", 64'(s_dc0), 64'hF);
        chk("sat_mm_hold",  64'(s_mm), 64'hF);
        chk("sat_rd_live",  64'(s_rd0), 64'd1);
        chk("sat_qid",      64'(s_qid), 64'd0);
        s_vld0 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end
endmodule
